// File: rtl/awg_cmd_deframer.sv
// Byte-stream command deframer for the AWG: hunts for SYNC_BYTE, decodes SAMPLES/ARM packets.
// Optional trailing XOR checksum byte is enabled by defining AWG_CHECKSUM_EN.
`timescale 1ns/1ps

module awg_cmd_deframer #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                 clk100,
  input  logic                 rst,
  input  logic [7:0]           s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [BIT_WIDTH-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 arm_pulse,
  output logic [1:0]           err,
  input  logic                 err_clr
);

  localparam logic [7:0] OPC_SAMPLES = 8'h01;
  localparam logic [7:0] OPC_ARM     = 8'h02;

  typedef enum logic [2:0] {
    HUNT,
    OPC,
    LEN_LO,
    LEN_HI,
    D_LO,
    D_HI,
    CHK
  } state_t;

  state_t      state;
  logic        is_arm;
  logic [7:0]  len_lo;
  logic [7:0]  data_lo;
  logic [15:0] remaining;
  logic [15:0] len_word;
  logic        accept;

  // A new byte may only land when the sample slot is free or draining this cycle.
  assign s_tready = !m_tvalid || m_tready;
  assign accept   = s_tvalid && s_tready;
  assign len_word = {s_tdata, len_lo};

`ifdef AWG_CHECKSUM_EN
  localparam state_t TAIL = CHK;

  logic [7:0] csum;

  // Running XOR of every byte after SYNC up to the checksum byte itself.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      csum <= 8'h00;
    end else if (accept) begin
      if (state == HUNT) begin
        csum <= 8'h00;
      end else if (state != CHK) begin
        csum <= csum ^ s_tdata;
      end
    end
  end
`else
  localparam state_t TAIL = HUNT;
`endif

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      is_arm    <= 1'b0;
      len_lo    <= 8'h00;
      data_lo   <= 8'h00;
      remaining <= 16'd0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      arm_pulse <= 1'b0;
      err       <= 2'b00;
    end else begin
      arm_pulse <= 1'b0;

      if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end

      // Clear first so an error flagged in the same cycle takes priority.
      if (err_clr) begin
        err <= 2'b00;
      end

      if (accept) begin
        case (state)
          HUNT: begin
            if (s_tdata == SYNC_BYTE) begin
              state <= OPC;
            end
          end

          OPC: begin
            if (s_tdata == OPC_SAMPLES) begin
              is_arm <= 1'b0;
              state  <= LEN_LO;
            end else if (s_tdata == OPC_ARM) begin
              is_arm <= 1'b1;
              state  <= LEN_LO;
            end else begin
              err[0] <= 1'b1;
              state  <= HUNT;
            end
          end

          LEN_LO: begin
            len_lo <= s_tdata;
            state  <= LEN_HI;
          end

          LEN_HI: begin
            if (is_arm) begin
`ifdef AWG_CHECKSUM_EN
              state <= CHK;
`else
              arm_pulse <= 1'b1;
              state     <= HUNT;
`endif
            end else if (len_word == 16'd0) begin
              state <= TAIL;
            end else begin
              remaining <= len_word;
              state     <= D_LO;
            end
          end

          D_LO: begin
            data_lo <= s_tdata;
            state   <= D_HI;
          end

          D_HI: begin
            m_tdata   <= BIT_WIDTH'({s_tdata, data_lo});
            m_tvalid  <= 1'b1;
            m_tlast   <= (remaining == 16'd1);
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state <= TAIL;
            end else begin
              state <= D_LO;
            end
          end

          CHK: begin
`ifdef AWG_CHECKSUM_EN
            if (s_tdata == csum) begin
              arm_pulse <= is_arm;
            end else begin
              err[1] <= 1'b1;
            end
`endif
            state <= HUNT;
          end

          default: begin
            state <= HUNT;
          end
        endcase
      end
    end
  end

endmodule
